pipe_pack_2: RTL
================

Name: pipe_pack_2

Overview:
- Feeder stage for the pairwise-sum pipeline.
- Accepts a serial stream of signed fixed-point words, one per `we_in` strobe.
- Packs consecutive words into a 2×WORD_LEN pair bus: first word in the low half, second word in the high half. This pair bus is the input format of the pair-sum stage.
- Tracks row boundaries. Odd-length rows are zero-padded so that no word leaks into the next row's pair.

Parameters:
- `WORD_LEN`, default 32 (from `macro.v`): width of one signed fixed-point word.
- `ROW_LEN`, default 4: words per matrix row, legal range 1..255. A row closes on reaching `ROW_LEN` words or on `last_in`, whichever comes first.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `we_in` input 1: input word valid, one word per asserted cycle; there is no backpressure.
- `In_word` input WORD_LEN: signed input word.
- `last_in` input 1: marks `In_word` as the final word of the row; qualified by `we_in`.
- `we_out` output 1: pair valid, single-cycle pulse.
- `Out_pair` output 2*WORD_LEN: {high word, low word}. Low = earlier word, bits [WORD_LEN-1:0]; high = later word.
- `last_out` output 1: `Out_pair` is the final pair of the row; valid with `we_out`.
- `pad_out` output 1: high half of `Out_pair` is a zero pad; valid with `we_out`.

Behaviour:
- Reset, at the `clk` edge with `rst`=1:
  - `we_out`=0, `Out_pair`=0, `last_out`=0, `pad_out`=0.
  - Holding register cleared, word counter=0, state=EMPTY.
  - Reset mid-row discards any held half-pair; no pair is emitted for it.
- States: EMPTY (no held word) and HALF (low word held).
- EMPTY with `we_in`=1:
  - Latch `In_word` into the holding register and increment the counter.
  - If `last_in`=1 or counter+1==`ROW_LEN`: emit {0, `In_word`} next cycle with `pad_out`=1 and `last_out`=1, reset the counter, stay in EMPTY.
  - Otherwise go to HALF.
- HALF with `we_in`=1:
  - Emit {`In_word`, held} next cycle and go to EMPTY.
  - `last_out`=1 if `last_in`=1 or counter+1==`ROW_LEN`; in that case also reset the counter.
  - `pad_out`=0.
- Cycles with `we_in`=0: no state change; `we_out`=0 next cycle.
- Outputs are registered:
  - Latency 1 cycle from the `we_in` edge of the word that completes a pair to the `we_out` pulse.
  - `Out_pair`, `last_out` and `pad_out` hold their last value while `we_out`=0.
- Throughput:
  - One word per cycle sustained, giving one pair every 2 cycles.
  - Back-to-back rows need no idle cycle.
- `last_in` while `we_in`=0 is ignored.
- Arithmetic: words pass through bit-exact; no sign extension, rounding or reordering within a half.

Optional Feature:
- Macro `PACK_ROW_CHECK_EN`.
- Defined:
  - Adds output `row_err` (1 bit, reset 0, sticky until `rst`).
  - `row_err` sets when `last_in` arrives with counter+1 != `ROW_LEN`.
  - An un-flagged row end at `ROW_LEN` does not set `row_err`.
- Undefined:
  - Port and comparison logic are absent.
  - `last_in` still closes the row early, silently.

Decomposition:
- `macro.v` holds `WORD_LEN`, the pair width 2*`WORD_LEN`, and the EMPTY/HALF state encodings. These are shared with the pair-sum stage, so pack and sum use the same half ordering.
- No sub-module: the word counter and 2-state FSM are small enough to live inline.

Test Plan:
- Row of 4 words 0x00010000, 0x00020000, 0xFFFF0000, 0x00003000 with `we_in` held high:
  - `we_out` pulses 2 cycles after word 1 and word 3.
  - `Out_pair`=0x00020000_00010000, then 0x00003000_FFFF0000.
  - `last_out`=1 on the second pair only.
- `ROW_LEN`=3, words 5, 6, 7:
  - Pairs are {6,5} then {0,7}.
  - Second pair has `pad_out`=1 and `last_out`=1.
  - The next row's first word lands in the low half.
- `ROW_LEN`=4, `last_in` on word 2 of 0x11, 0x22:
  - Single pair {0x22,0x11} with `last_out`=1.
  - With `PACK_ROW_CHECK_EN` defined, `row_err`=1 the next cycle and stays 1.
- Gapped input (word, 3 idle cycles, word):
  - One pair, emitted 1 cycle after the second word.
  - `we_out`=0 throughout the gap.
- Reset asserted while in HALF with 0xABCD held, then words 1, 2:
  - No pair containing 0xABCD.
  - Next pair is {2,1}; all outputs read 0 in the cycle after reset.
- `ROW_LEN`=1, words 9, 10 back-to-back:
  - Pairs {0,9} and {0,10} on consecutive cycles, each with `pad_out`=1 and `last_out`=1.

Source files
------------

// File: rtl/pipe_pack_2_pkg.sv
// Shared definitions for the pair-pack feeder and the pair-sum stage:
// word/pair widths, state encodings and the row-length helper.
package pipe_pack_2_pkg;

  localparam int PP_WORD_LEN = 32;
  localparam int PP_PAIR_LEN = 2 * PP_WORD_LEN;
  localparam int PP_CNT_W    = 8;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } pack_state_e;

  // True when the word being accepted now is the last one a full row can hold.
  function automatic logic row_full(input logic [PP_CNT_W-1:0] cnt,
                                    input logic [PP_CNT_W:0]   row_len);
    return (({1'b0, cnt} + 9'd1) == row_len);
  endfunction

endpackage

// File: rtl/pipe_pack_2_if.sv
// Word-in / pair-out bus of the pair-pack feeder.
// With PACK_ROW_CHECK_EN defined the bus also carries the sticky row_err flag.
interface pipe_pack_2_if #(
  parameter int WORD_LEN = pipe_pack_2_pkg::PP_WORD_LEN
) ();

  logic                  we_in;
  logic [WORD_LEN-1:0]   In_word;
  logic                  last_in;
  logic                  we_out;
  logic [2*WORD_LEN-1:0] Out_pair;
  logic                  last_out;
  logic                  pad_out;
`ifdef PACK_ROW_CHECK_EN
  logic                  row_err;

  modport master (
    output we_in, In_word, last_in,
    input  we_out, Out_pair, last_out, pad_out, row_err
  );

  modport slave (
    input  we_in, In_word, last_in,
    output we_out, Out_pair, last_out, pad_out, row_err
  );
`else
  modport master (
    output we_in, In_word, last_in,
    input  we_out, Out_pair, last_out, pad_out
  );

  modport slave (
    input  we_in, In_word, last_in,
    output we_out, Out_pair, last_out, pad_out
  );
`endif

endinterface

// File: rtl/pipe_pack_2.sv
// Packs a serial word stream into {later, earlier} pairs, padding odd row tails with zero.
// Optional row-length checking is built when PACK_ROW_CHECK_EN is defined.
module pipe_pack_2
  import pipe_pack_2_pkg::*;
#(
  parameter int WORD_LEN = PP_WORD_LEN,
  parameter int ROW_LEN  = 4
) (
  input  logic         clk,
  input  logic         rst,
  pipe_pack_2_if.slave bus
);

  localparam logic [PP_CNT_W:0] ROW_LEN_V = (PP_CNT_W+1)'(ROW_LEN);

  pack_state_e           state_q, state_d;
  logic [PP_CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORD_LEN-1:0]   hold_q, hold_d;
  logic                  we_out_q, we_out_d;
  logic [2*WORD_LEN-1:0] pair_q, pair_d;
  logic                  last_q, last_d;
  logic                  pad_q, pad_d;
  logic                  row_end_s;

  // Next-state, counter and output-pair selection.
  always_comb begin
    row_end_s = bus.last_in || row_full(cnt_q, ROW_LEN_V);
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    we_out_d  = 1'b0;
    pair_d    = pair_q;
    last_d    = last_q;
    pad_d     = pad_q;
    if (bus.we_in) begin
      case (state_q)
        ST_EMPTY: begin
          hold_d = bus.In_word;
          if (row_end_s) begin
            // Lone word closes the row: emit it with a zero high half.
            we_out_d = 1'b1;
            pair_d   = {{WORD_LEN{1'b0}}, bus.In_word};
            last_d   = 1'b1;
            pad_d    = 1'b1;
            cnt_d    = {PP_CNT_W{1'b0}};
            state_d  = ST_EMPTY;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            state_d = ST_HALF;
          end
        end
        ST_HALF: begin
          we_out_d = 1'b1;
          pair_d   = {bus.In_word, hold_q};
          last_d   = row_end_s;
          pad_d    = 1'b0;
          if (row_end_s) begin
            cnt_d = {PP_CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
          state_d = ST_EMPTY;
        end
        default: begin
          cnt_d   = {PP_CNT_W{1'b0}};
          state_d = ST_EMPTY;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State, holding register and registered pair outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      cnt_q    <= {PP_CNT_W{1'b0}};
      hold_q   <= {WORD_LEN{1'b0}};
      we_out_q <= 1'b0;
      pair_q   <= {(2*WORD_LEN){1'b0}};
      last_q   <= 1'b0;
      pad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      we_out_q <= we_out_d;
      pair_q   <= pair_d;
      last_q   <= last_d;
      pad_q    <= pad_d;
    end
  end

  assign bus.we_out   = we_out_q;
  assign bus.Out_pair = pair_q;
  assign bus.last_out = last_q;
  assign bus.pad_out  = pad_q;

`ifdef PACK_ROW_CHECK_EN
  logic row_err_q, row_err_d;

  // Flag any row that last_in closes short of ROW_LEN; sticky until reset.
  always_comb begin
    row_err_d = row_err_q;
    if (bus.we_in && bus.last_in && !row_full(cnt_q, ROW_LEN_V)) begin
      row_err_d = 1'b1;
    end else begin
      row_err_d = row_err_q;
    end
  end

  // Row error flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_err_q <= 1'b0;
    end else begin
      row_err_q <= row_err_d;
    end
  end

  assign bus.row_err = row_err_q;
`endif

endmodule
